// File: rtl/ps2_key_receiver.sv
// rtl/ps2_key_receiver.sv - PS/2 keyboard frame deserializer with parity/framing/timeout checks
// Optional feature macro: PS2_BREAK_FILTER_EN (suppresses 8'hF0 break prefix and the byte after it)
module ps2_key_receiver #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic [7:0] ps2_out,
  output logic       ps2_key_pressed,
  output logic       parity_error,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // synchronizer and edge-detect flops
  logic clk_s1_q, clk_s1_d;
  logic clk_s_q,  clk_s_d;
  logic clk_d_q,  clk_d_d;
  logic dat_s1_q, dat_s1_d;
  logic dat_s_q,  dat_s_d;

  // frame state
  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      data_q, data_d;
  logic            parity_q, parity_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;

  // registered outputs
  logic [7:0]      out_q, out_d;
  logic            key_q, key_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;

`ifdef PS2_BREAK_FILTER_EN
  logic            break_pending_q, break_pending_d;
`endif

  logic            fall;
  logic            dat_s;
  logic            accept;

  assign fall  = clk_d_q & ~clk_s_q;
  assign dat_s = dat_s_q;

  assign ps2_out         = out_q;
  assign ps2_key_pressed = key_q;
  assign parity_error    = perr_q;
  assign frame_error     = ferr_q;

  // two-stage synchronizers on both pins plus a delay stage on the clock for edge detection
  always_comb begin
    clk_s1_d = ps2_clock;
    clk_s_d  = clk_s1_q;
    clk_d_d  = clk_s_q;
    dat_s1_d = ps2_data;
    dat_s_d  = dat_s1_q;
  end

  // synchronizer flops reset high so releasing reset never fakes a falling edge
  always_ff @(posedge clock) begin
    if (!reset) begin
      clk_s1_q <= 1'b1;
      clk_s_q  <= 1'b1;
      clk_d_q  <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s_q  <= 1'b1;
    end else begin
      clk_s1_q <= clk_s1_d;
      clk_s_q  <= clk_s_d;
      clk_d_q  <= clk_d_d;
      dat_s1_q <= dat_s1_d;
      dat_s_q  <= dat_s_d;
    end
  end

  // frame FSM, timeout watchdog and strobe generation
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    parity_d  = parity_q;
    out_d     = out_q;
    key_d     = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    accept    = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
    break_pending_d = break_pending_q;
`endif

    // watchdog only runs while a frame is in progress; every edge restarts it
    if (fall || (state_q == S_IDLE)) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end else begin
      to_cnt_d = to_cnt_q;
    end

    case (state_q)
      S_IDLE: begin
        // a high data bit on an edge here is a glitch and is silently ignored
        if (fall && !dat_s) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (fall) begin
          data_d[bit_cnt_q] = dat_s;
          bit_cnt_d         = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (fall) begin
          parity_d = dat_s;
          state_d  = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          state_d = S_IDLE;
          if (!dat_s) begin
            ferr_d = 1'b1;
          end else if (^{data_q, parity_q} != 1'b1) begin
            perr_d = 1'b1;
          end else begin
            accept = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // an edge in the same cycle wins over the timeout
    if (!fall && (state_q != S_IDLE) && (to_cnt_q == TO_MAX)) begin
      state_d = S_IDLE;
      ferr_d  = 1'b1;
    end

`ifdef PS2_BREAK_FILTER_EN
    // F0 arms the filter; the following byte disarms it; neither reaches the consumer
    if (accept) begin
      if (break_pending_q) begin
        break_pending_d = 1'b0;
      end else if (data_q == 8'hF0) begin
        break_pending_d = 1'b1;
      end else begin
        out_d = data_q;
        key_d = 1'b1;
      end
    end
`else
    if (accept) begin
      out_d = data_q;
      key_d = 1'b1;
    end
`endif
  end

  // frame state and output registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 3'd0;
      data_q    <= 8'h00;
      parity_q  <= 1'b0;
      to_cnt_q  <= '0;
      out_q     <= 8'h00;
      key_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      to_cnt_q  <= to_cnt_d;
      out_q     <= out_d;
      key_q     <= key_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  // break-prefix flag survives errors and timeouts, cleared only by reset or the next good byte
  always_ff @(posedge clock) begin
    if (!reset) begin
      break_pending_q <= 1'b0;
    end else begin
      break_pending_q <= break_pending_d;
    end
  end
`endif

endmodule

// File: tb/tb_ps2_key_receiver.sv
// tb/tb_ps2_key_receiver.sv - directed self-checking bench for ps2_key_receiver
`timescale 1ns/1ps
module tb_ps2_key_receiver;

  // 1 MHz system clock; 50-cycle half period gives a 10 kHz PS/2 clock
  localparam int HALF = 50;
  localparam int TO   = 400;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clock = 1'b1;
  logic       ps2_data  = 1'b1;
  logic [7:0] ps2_out;
  logic       ps2_key_pressed;
  logic       parity_error;
  logic       frame_error;

  int vecs = 0;
  int errs = 0;
  int kp_cnt = 0, pe_cnt = 0, fe_cnt = 0;
  int multi_cnt = 0, long_cnt = 0;
  logic prev_kp = 1'b0, prev_pe = 1'b0, prev_fe = 1'b0;
  int k0, p0, f0;

  ps2_key_receiver #(.TIMEOUT_CYCLES(TO)) dut (
    .clock           (clock),
    .reset           (reset),
    .ps2_clock       (ps2_clock),
    .ps2_data        (ps2_data),
    .ps2_out         (ps2_out),
    .ps2_key_pressed (ps2_key_pressed),
    .parity_error    (parity_error),
    .frame_error     (frame_error)
  );

  always #500 clock = ~clock;

  // strobe counters sampled away from the active edge
  always @(negedge clock) begin
    if (ps2_key_pressed) kp_cnt++;
    if (parity_error)    pe_cnt++;
    if (frame_error)     fe_cnt++;
    if ((int'(ps2_key_pressed) + int'(parity_error) + int'(frame_error)) > 1) multi_cnt++;
    if ((ps2_key_pressed && prev_kp) || (parity_error && prev_pe) || (frame_error && prev_fe)) long_cnt++;
    prev_kp = ps2_key_pressed;
    prev_pe = parity_error;
    prev_fe = frame_error;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input logic par, input logic stop);
    return {stop, par, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      ps2_data = bits[i];
      repeat (HALF) @(negedge clock);
      ps2_clock = 1'b0;
      repeat (HALF) @(negedge clock);
      ps2_clock = 1'b1;
    end
    @(negedge clock);
    ps2_data = 1'b1;
    repeat (20) @(negedge clock);
  endtask

  task automatic snap();
    k0 = kp_cnt;
    p0 = pe_cnt;
    f0 = fe_cnt;
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_out", 32'(ps2_out), 32'h00);
    check("rst_kp", 32'(ps2_key_pressed), 32'h0);
    check("rst_pe", 32'(parity_error), 32'h0);
    check("rst_fe", 32'(frame_error), 32'h0);
    reset = 1'b1;
    repeat (10) @(negedge clock);

    // valid 0x1C: three ones -> parity 0
    snap();
    send_bits(frame(8'h1C, 1'b0, 1'b1), 11);
    check("v1c_kp", 32'(kp_cnt - k0), 32'd1);
    check("v1c_out", 32'(ps2_out), 32'h1C);
    check("v1c_pe", 32'(pe_cnt - p0), 32'd0);
    check("v1c_fe", 32'(fe_cnt - f0), 32'd0);

    // 0x5A with wrong parity 0
    snap();
    send_bits(frame(8'h5A, 1'b0, 1'b1), 11);
    check("par_pe", 32'(pe_cnt - p0), 32'd1);
    check("par_kp", 32'(kp_cnt - k0), 32'd0);
    check("par_out", 32'(ps2_out), 32'h1C);

    // 0x5A correct parity, stop bit 0
    snap();
    send_bits(frame(8'h5A, 1'b1, 1'b0), 11);
    check("stop_fe", 32'(fe_cnt - f0), 32'd1);
    check("stop_pe", 32'(pe_cnt - p0), 32'd0);
    check("stop_kp", 32'(kp_cnt - k0), 32'd0);
    check("stop_out", 32'(ps2_out), 32'h1C);

    // start + 4 data bits then idle past the timeout
    snap();
    send_bits(frame(8'h5A, 1'b1, 1'b1), 5);
    repeat (TO + 5) @(negedge clock);
    check("to_fe", 32'(fe_cnt - f0), 32'd1);
    check("to_kp", 32'(kp_cnt - k0), 32'd0);
    snap();
    send_bits(frame(8'h5A, 1'b1, 1'b1), 11);
    check("to_next_kp", 32'(kp_cnt - k0), 32'd1);
    check("to_next_out", 32'(ps2_out), 32'h5A);
    check("to_next_fe", 32'(fe_cnt - f0), 32'd0);

    // reset after 6th data bit of 0xC0; remaining bits are all 1 and look like idle glitches
    snap();
    send_bits(frame(8'hC0, 1'b1, 1'b1), 7);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    send_bits(11'h00F, 4);
    check("mid_rst_kp", 32'(kp_cnt - k0), 32'd0);
    check("mid_rst_pe", 32'(pe_cnt - p0), 32'd0);
    check("mid_rst_fe", 32'(fe_cnt - f0), 32'd0);
    check("mid_rst_out", 32'(ps2_out), 32'h00);
    snap();
    send_bits(frame(8'h1C, 1'b0, 1'b1), 11);
    check("post_rst_kp", 32'(kp_cnt - k0), 32'd1);
    check("post_rst_out", 32'(ps2_out), 32'h1C);

    // 0x1C, 0xF0 (four ones -> parity 1), 0x1C
    snap();
    send_bits(frame(8'h1C, 1'b0, 1'b1), 11);
    send_bits(frame(8'hF0, 1'b1, 1'b1), 11);
    send_bits(frame(8'h1C, 1'b0, 1'b1), 11);
`ifdef PS2_BREAK_FILTER_EN
    check("brk_kp", 32'(kp_cnt - k0), 32'd1);
`else
    check("brk_kp", 32'(kp_cnt - k0), 32'd3);
`endif
    check("brk_out", 32'(ps2_out), 32'h1C);
    check("brk_err", 32'(pe_cnt - p0 + fe_cnt - f0), 32'd0);

    // next byte after the sequence is always delivered
    snap();
    send_bits(frame(8'h5A, 1'b1, 1'b1), 11);
    check("after_kp", 32'(kp_cnt - k0), 32'd1);
    check("after_out", 32'(ps2_out), 32'h5A);

    check("one_hot_strobes", 32'(multi_cnt), 32'd0);
    check("strobe_width", 32'(long_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
